// File: rtl/nabp_shifter_sequencer.sv
`default_nettype none
// ============================================================================
// nabp_shifter_sequencer
// Angle -> tan/cot look-up -> fractional accumulator; emits one shift/no-shift
// decision per step over a valid/ready stream. Optional macro:
// NABP_SHIFTER_ROUND_EN (accumulator starts at 0.5 so shifts round to nearest).
// Revision: 1.0
// ============================================================================
module nabp_shifter_sequencer #(
    parameter int kAngleLength   = 9,
    parameter int kAccuPrecision = 8,
    parameter int kSteps         = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      angle_valid,
    input  logic [kAngleLength-1:0]   angle,
    output logic                      angle_ready,
    output logic                      angle_err,
    output logic [kAngleLength-1:0]   lut_angle,
    input  logic [kAccuPrecision:0]   lut_accu_base,
    output logic                      swap_dir,
    output logic                      shift_valid,
    input  logic                      shift_ready,
    output logic                      shift_en,
    output logic                      shift_last,
    output logic                      busy
);

    localparam int P      = kAccuPrecision;
    localparam int STEP_W = $clog2(kSteps);

    localparam logic [kAngleLength-1:0] c_ANGLE_LIMIT = kAngleLength'(180);
    localparam logic [kAngleLength-1:0] c_ANGLE_45    = kAngleLength'(45);
    localparam logic [kAngleLength-1:0] c_ANGLE_135   = kAngleLength'(135);
    localparam logic [STEP_W-1:0]       c_LAST_STEP   = STEP_W'(kSteps - 1);

`ifdef NABP_SHIFTER_ROUND_EN
    localparam logic [P-1:0] c_ACC_INIT = {1'b1, {(P-1){1'b0}}};
`else
    localparam logic [P-1:0] c_ACC_INIT = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_LOAD   = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [P-1:0]              acc_q, acc_d;
    logic [P:0]                base_q, base_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [kAngleLength-1:0]   lut_angle_q, lut_angle_d;
    logic                      swap_dir_q, swap_dir_d;
    logic                      err_q, err_d;

    logic [P+1:0]              w_sum;
    logic                      w_run;
    logic                      w_last;

    // sum < 2.0, so any set integer bit means exactly one carry this step
    assign w_sum  = {2'b00, acc_q} + {1'b0, base_q};
    assign w_run  = (state_q == S_RUN);
    assign w_last = (step_q == c_LAST_STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            step_q      <= '0;
            lut_angle_q <= '0;
            swap_dir_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            step_q      <= step_d;
            lut_angle_q <= lut_angle_d;
            swap_dir_q  <= swap_dir_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        step_d      = step_q;
        lut_angle_d = lut_angle_q;
        swap_dir_d  = swap_dir_q;
        err_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (angle_valid) begin
                    if (angle >= c_ANGLE_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        lut_angle_d = angle;
                        swap_dir_d  = (angle >= c_ANGLE_45) && (angle < c_ANGLE_135);
                        state_d     = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                base_d  = lut_accu_base;
                acc_d   = c_ACC_INIT;
                step_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (shift_ready) begin
                    acc_d  = w_sum[P-1:0];
                    step_d = step_q + 1'b1;
                    if (w_last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ready is forced low during reset so no angle is taken while held in reset
    assign angle_ready = (state_q == S_IDLE) && !reset;
    assign angle_err   = err_q;
    assign lut_angle   = lut_angle_q;
    assign swap_dir    = swap_dir_q;
    assign shift_valid = w_run;
    assign shift_en    = w_run && (|w_sum[P+1:P]);
    assign shift_last  = w_run && w_last;
    assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nabp_shifter_sequencer.sv
`default_nettype none
// ============================================================================
// tb_nabp_shifter_sequencer
// Self-checking bench: closed-form step model plus a registered look-up table.
// Revision: 1.0
// ============================================================================
module tb_nabp_shifter_sequencer;

    localparam int P      = 8;
    localparam int NSTEPS = 256;
`ifdef NABP_SHIFTER_ROUND_EN
    localparam int ACC_I   = 128;
    localparam int FIRST30 = 0;
`else
    localparam int ACC_I   = 0;
    localparam int FIRST30 = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       angle_valid = 1'b0;
    logic [8:0] angle = '0;
    logic       angle_ready;
    logic       angle_err;
    logic [8:0] lut_angle;
    logic [8:0] lut_q = '0;
    logic       swap_dir;
    logic       shift_valid;
    logic       shift_ready = 1'b1;
    logic       shift_en;
    logic       shift_last;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int rdy_mode = 0;
    int err_seen = 0;

    bit in_line = 1'b0;
    int wait_c = 0;
    bit err_pend = 1'b0;
    int k = 0;
    int line_angle = 0;
    int line_base = 0;
    int shifts = 0;
    int first = -1;

    nabp_shifter_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .angle_valid   (angle_valid),
        .angle         (angle),
        .angle_ready   (angle_ready),
        .angle_err     (angle_err),
        .lut_angle     (lut_angle),
        .lut_accu_base (lut_q),
        .swap_dir      (swap_dir),
        .shift_valid   (shift_valid),
        .shift_ready   (shift_ready),
        .shift_en      (shift_en),
        .shift_last    (shift_last),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic int tab(input int a);
        if (a == 0) return 0;
        if (a == 45 || a == 135) return 256;
        if (a == 30) return 148;
        return (a * 53) % 257;
    endfunction

    // number of whole units crossed between step kk and kk+1
    function automatic int exp_en(input int b, input int kk);
        return ((ACC_I + (kk + 1) * b) >> P) - ((ACC_I + kk * b) >> P);
    endfunction

    always @(posedge clk) lut_q <= 9'(tab(int'(lut_angle)));

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       shift_ready = 1'b1;
            1:       shift_ready = (($urandom % 4) != 0);
            default: shift_ready = 1'b0;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        bit idle_now;
        bit ev;
        if (reset) begin
            chk("rst_angle_ready", int'(angle_ready), 0);
            chk("rst_angle_err",   int'(angle_err), 0);
            chk("rst_shift_valid", int'(shift_valid), 0);
            chk("rst_shift_en",    int'(shift_en), 0);
            chk("rst_shift_last",  int'(shift_last), 0);
            chk("rst_busy",        int'(busy), 0);
            chk("rst_lut_angle",   int'(lut_angle), 0);
            chk("rst_swap_dir",    int'(swap_dir), 0);
            in_line  = 1'b0;
            wait_c   = 0;
            err_pend = 1'b0;
            k        = 0;
        end else begin
            idle_now = !in_line;
            if (wait_c > 0) wait_c--;
            ev = in_line && (wait_c == 0);
            if (angle_err) err_seen++;
            chk("shift_valid", int'(shift_valid), int'(ev));
            chk("busy",        int'(busy), int'(in_line));
            chk("angle_ready", int'(angle_ready), int'(!in_line));
            chk("angle_err",   int'(angle_err), int'(err_pend));
            err_pend = 1'b0;
            if (in_line) begin
                chk("lut_angle", int'(lut_angle), line_angle);
                chk("swap_dir", int'(swap_dir), int'(line_angle >= 45 && line_angle < 135));
            end
            if (ev) begin
                chk("shift_en",   int'(shift_en), exp_en(line_base, k));
                chk("shift_last", int'(shift_last), int'(k == NSTEPS - 1));
                if (shift_ready) begin
                    if (shift_en) begin
                        shifts++;
                        if (first < 0) first = k;
                    end
                    if (k == NSTEPS - 1) begin
                        in_line = 1'b0;
                        if (line_angle == 0) chk("a0_total_shifts", shifts, 0);
                        if (line_angle == 45 || line_angle == 135) chk("a45_total_shifts", shifts, 256);
                        if (line_angle == 30) begin
                            chk("a30_total_shifts", shifts, 148);
                            chk("a30_first_shift", first, FIRST30);
                        end
                    end
                    k++;
                end
            end else begin
                chk("idle_shift_en",   int'(shift_en), 0);
                chk("idle_shift_last", int'(shift_last), 0);
            end
            if (idle_now && angle_valid) begin
                if (int'(angle) >= 180) begin
                    err_pend = 1'b1;
                end else begin
                    in_line    = 1'b1;
                    wait_c     = 3;
                    k          = 0;
                    line_angle = int'(angle);
                    line_base  = tab(line_angle);
                    shifts     = 0;
                    first      = -1;
                end
            end
        end
    end

    task automatic send(input int a);
        int n;
        n = 0;
        @(posedge clk); #1;
        angle_valid = 1'b1;
        angle       = 9'(a);
        while (n < 2000) begin
            @(negedge clk);
            if (angle_ready) break;
            n++;
        end
        if (n >= 2000) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        angle_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        if (n >= 3000) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (n < 3000) begin
            @(posedge clk); #1;
            if (in_line && k == target) break;
            n++;
        end
        if (n >= 3000) chk("step_timeout", 0, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        send(0);   wait_idle();
        send(45);  wait_idle();
        send(30);  wait_idle();

        send(200);
        repeat (4) @(posedge clk);
        chk("err_pulse_count", err_seen, 1);

        // backpressure in the middle of a line
        send(30);
        wait_k(10);
        rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1 rdy_mode = 0;
        wait_idle();

        // second angle offered while the first line is still running
        send(135);
        send(90);
        wait_idle();

        // reset in the middle of a line, then a clean restart
        send(30);
        wait_k(100);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send(45);
        wait_idle();

        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            int a;
            a = $urandom_range(0, 199);
            send(a);
            if (a < 180) wait_idle();
            else repeat (3) @(posedge clk);
        end
        rdy_mode = 0;
        repeat (4) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, fails=%0d", fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/nabp_shifter_sequencer.md
# nabp_shifter_sequencer

Initiator side of the shifter look-up: accepts one projection angle per line, drives the angle into the tan/cot look-up table, captures the returned fixed-point step increment, then runs a fractional accumulator for `kSteps` steps. Each step it emits a shift/no-shift decision to the NABP line buffer over a valid/ready stream. It sits between the angle scheduler upstream and the shifter buffer downstream.

## Interface
- `kAngleLength`, 9: angle width; angles are integer degrees.
- `kAccuPrecision`, 8: fractional bits `P` of the step increment; the increment is unsigned fixed point 1.P (P+1 bits).
- `kSteps`, 256: steps per line (at least 2).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `angle_valid`  in  1  upstream angle offered.
- `angle`  in  `kAngleLength`  projection angle, valid range 0–179.
- `angle_ready`  out  1  high only in IDLE.
- `angle_err`  out  1  one-cycle pulse: an out-of-range angle was accepted.
- `lut_angle`  out  `kAngleLength`  angle presented to the look-up table.
- `lut_accu_base`  in  P+1  look-up result; registered in the table, valid one cycle after `lut_angle` is sampled.
- `swap_dir`  out  1  1 when the captured angle is in [45,135) (cot region), 0 otherwise; held for the whole line.
- `shift_valid`  out  1  step decision available.
- `shift_ready`  in  1  downstream accepts the step.
- `shift_en`  out  1  1 means shift the buffer on this step.
- `shift_last`  out  1  marks the final step of the line.
- `busy`  out  1  high when not in IDLE.

## Operation
- FSM states: IDLE, LOOKUP, LOAD, RUN.
- IDLE:
  - On `angle_valid` high, the angle is accepted (`angle_ready` is 1 in IDLE).
  - If `angle` ≥ 180: pulse `angle_err` for one cycle and stay in IDLE.
  - Otherwise: register `lut_angle <= angle`, set `swap_dir` from the angle, go to LOOKUP.
- LOOKUP: wait one cycle while the table samples `lut_angle`; go to LOAD.
- LOAD:
  - Capture `lut_accu_base` into `base`.
  - Set `acc <= ACC_INIT` and `step <= 0`; go to RUN.
- RUN:
  - Compute `sum = acc + base` in P+2 bits. Since `acc` < 1.0 and `base` ≤ 1.0, `sum` < 2.0.
  - `shift_en = sum[P]` (integer carry).
  - `shift_last = (step == kSteps-1)`.
  - `shift_valid = 1`.
  - On handshake (`shift_valid && shift_ready`): `acc <= sum[P-1:0]`, `step <= step+1`. If `shift_last`, go to IDLE.
- Backpressure: while `shift_ready` is low, `acc`, `step`, `shift_en` and `shift_last` hold.
- Upstream stall: `angle_valid` is ignored outside IDLE; the angle stays pending upstream.
- Base boundary values:
  - `base` = 0 (angle 0): `shift_en` is never asserted.
  - `base` = 1.0 (angles 45 and 135): `shift_en` is asserted on every step.
- Reset values, applied at reset assertion, including mid-line:
  - state IDLE;
  - `acc`, `base`, `step`, `lut_angle`, `swap_dir` = 0;
  - `angle_ready` = 0 while reset is high, 1 in the first cycle after release;
  - `angle_err`, `shift_valid`, `shift_en`, `shift_last` = 0;
  - `busy` = 0.

## Timing
- Angle accepted at edge T0:
  - `lut_angle` is valid after T0.
  - The table registers its output at T1.
  - `base` is captured at T2.
  - `shift_valid` is first high in the cycle after T2.
- Latency from angle acceptance to first step: 3 cycles.
- Throughput: one step per cycle when `shift_ready` is held high.
- Line period: `kSteps` + 3 cycles, plus 1 IDLE cycle before the next angle.
- `shift_en` and `shift_last` are combinational from registered `acc`, `base` and `step`. They are stable for the whole time `shift_valid` is high.
- `angle_err` is registered: it pulses in the cycle after the acceptance edge.

## Configuration
- `NABP_SHIFTER_ROUND_EN`:
  - Defined: `ACC_INIT` = 0.5 (bit P-1 set), so shifts round to the nearest step.
  - Undefined: `ACC_INIT` = 0, so shifts truncate.
- Nothing else changes between the two builds.

## Test plan
- Angle 0, `base` 0x000, `shift_ready` = 1 → 256 steps, all with `shift_en` = 0; `shift_last` only on step 255; `angle_ready` returns after the line.
- Angle 45, `base` 0x100 → `shift_en` = 1 on all 256 steps; `swap_dir` = 1.
- Angle 30, `base` 0x094 (148):
  - Without round: first `shift_en` on step 1; 148 shifts total.
  - With `NABP_SHIFTER_ROUND_EN`: first `shift_en` on step 0; 148 shifts total.
- Angle 30, `shift_ready` low for 5 cycles at step 10 → `shift_en`, `shift_last` and step index unchanged during the stall; after the stall, the shift sequence is identical to the unstalled run.
- Angle 200 → one-cycle `angle_err` pulse; no `shift_valid`; `busy` stays 0.
- `reset` asserted at step 100 of a line → all outputs go to their reset values immediately; a new angle is accepted after reset release and the next line starts cleanly.
